// File: rtl/cache_axi_pkg.sv
// Shared AXI encodings and cache line-fill types for the complex cache memory side.
package cache_axi_pkg;

   localparam logic [1:0] AXI_BURST_INCR = 2'b01;
   localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
   localparam logic [2:0] AXI_SIZE_4B    = 3'b010;

   localparam int LINE_WORDS_DEF = 8;
   localparam int DATA_W_DEF     = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      DATA = 2'd2,
      DONE = 2'd3
   } fill_state_t;

   typedef logic [LINE_WORDS_DEF-1:0][DATA_W_DEF-1:0] line_t;

endpackage

// File: rtl/cache_line_fill_axi.sv
// AXI4 read master that fetches one cache line per miss as a single INCR burst
// and hands the assembled line to the cache with a one-cycle fill pulse.
module cache_line_fill_axi
   import cache_axi_pkg::*;
#(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int LINE_WORDS = 8
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         req_valid,
   output logic                         req_ready,
   input  logic [ADDR_W-1:0]            req_addr,
   output logic                         fill_valid,
   output logic [ADDR_W-1:0]            fill_addr,
   output logic [LINE_WORDS*DATA_W-1:0] fill_data,
   output logic                         fill_err,
   output logic [ADDR_W-1:0]            m_axi_araddr,
   output logic [7:0]                   m_axi_arlen,
   output logic [2:0]                   m_axi_arsize,
   output logic [1:0]                   m_axi_arburst,
   output logic                         m_axi_arvalid,
   input  logic                         m_axi_arready,
   input  logic [DATA_W-1:0]            m_axi_rdata,
   input  logic [1:0]                   m_axi_rresp,
   input  logic                         m_axi_rlast,
   input  logic                         m_axi_rvalid,
   output logic                         m_axi_rready
);

   localparam int IDX_W = $clog2(LINE_WORDS);
   localparam int CNT_W = IDX_W + 1;
   localparam int OFF_W = $clog2(LINE_WORDS * 4);
   localparam logic [ADDR_W-1:0] LINE_MASK = ~((ADDR_W'(1) << OFF_W) - ADDR_W'(1));

   fill_state_t       state_reg, state_next;
   logic [ADDR_W-1:0] addr_reg;
   logic [CNT_W-1:0]  beat_cnt_reg;
   logic              err_reg;
   logic              req_ready_reg, arvalid_reg, rready_reg, fill_valid_reg;

   logic req_fire, ar_fire, beat_fire, last_beat, burst_end;

   assign req_fire  = (state_reg == IDLE) && req_ready_reg && req_valid;
   assign ar_fire   = arvalid_reg && m_axi_arready;
   assign beat_fire = rready_reg && m_axi_rvalid;
   assign last_beat = (beat_cnt_reg == CNT_W'(LINE_WORDS - 1));
   // Either an rlast or the final expected beat closes the burst; disagreement is flagged below.
   assign burst_end = beat_fire && (m_axi_rlast || last_beat);

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (req_fire)  state_next = ADDR;
         ADDR:    if (ar_fire)   state_next = DATA;
         DATA:    if (burst_end) state_next = DONE;
         DONE:                   state_next = IDLE;
         default:                state_next = IDLE;
      endcase
   end

   // Handshake outputs are registered from the next state so they are clean flops and read 0 in reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg      <= IDLE;
         req_ready_reg  <= 1'b0;
         arvalid_reg    <= 1'b0;
         rready_reg     <= 1'b0;
         fill_valid_reg <= 1'b0;
      end else begin
         state_reg      <= state_next;
         req_ready_reg  <= (state_next == IDLE);
         arvalid_reg    <= (state_next == ADDR);
         rready_reg     <= (state_next == DATA);
         fill_valid_reg <= (state_next == DONE);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_reg     <= '0;
         beat_cnt_reg <= '0;
         err_reg      <= 1'b0;
      end else if (req_fire) begin
         addr_reg     <= req_addr & LINE_MASK;
         beat_cnt_reg <= '0;
         err_reg      <= 1'b0;
      end else if (beat_fire) begin
         beat_cnt_reg <= beat_cnt_reg + CNT_W'(1);
         if ((m_axi_rresp != AXI_RESP_OKAY) || (m_axi_rlast != last_beat)) begin
            err_reg <= 1'b1;
         end
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < LINE_WORDS; gi++) begin : g_word
         logic [DATA_W-1:0] word_reg;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               word_reg <= '0;
            end else if (beat_fire && (beat_cnt_reg[IDX_W-1:0] == IDX_W'(gi))) begin
               word_reg <= m_axi_rdata;
            end
         end

         assign fill_data[gi*DATA_W +: DATA_W] = word_reg;
      end
   endgenerate

   assign req_ready     = req_ready_reg;
   assign fill_valid    = fill_valid_reg;
   assign fill_addr     = addr_reg;
   assign fill_err      = fill_valid_reg && err_reg;
   assign m_axi_araddr  = addr_reg;
   assign m_axi_arlen   = 8'(LINE_WORDS - 1);
   assign m_axi_arsize  = AXI_SIZE_4B;
   assign m_axi_arburst = AXI_BURST_INCR;
   assign m_axi_arvalid = arvalid_reg;
   assign m_axi_rready  = rready_reg;

endmodule
